pool_window_feeder: RTL and testbench

POOL_WINDOW_FEEDER -- requirements
Module: pool_window_feeder

---
 rtl/pool_window_feeder.sv | 198 +++++++++++++++++++
 tb/tb_pool_window_feeder.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pool_window_feeder.sv
// Turns a raster pixel stream into 2x2 pooling windows: an even row is buffered,
// then each odd-row pixel pair is joined with the buffered pair and emitted as four beats.
module pool_window_feeder #(
    parameter int ROW_W = 8,
    parameter int IMG_H = 8
) (
    input  logic               clk,
    input  logic               n_reset,
    input  logic               run,
    input  logic               in_valid,
    input  logic signed [15:0] in_data,
    output logic               in_ready,
    output logic               out_start,
    output logic               out_enable,
    output logic signed [15:0] out_data,
    output logic               frame_done
);

    localparam int CW = (ROW_W > 1) ? $clog2(ROW_W) : 1;
    localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam logic [CW-1:0] COL_LAST = CW'(ROW_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
    // Beat value 4 is the idle gap that closes every window.
    localparam logic [2:0]    BEAT_GAP = 3'd4;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FILL   = 3'd1,
        LOAD_A = 3'd2,
        LOAD_B = 3'd3,
        EMIT   = 3'd4
    } state_t;

    state_t             state_r;
    state_t             next_state_s;
    logic [2:0]         beat_r;
    logic [2:0]         next_beat_s;
    logic [CW-1:0]      col_r;
    logic [CW-1:0]      base_r;
    logic [RW-1:0]      row_r;
    logic signed [15:0] hold_a_r;
    logic signed [15:0] hold_b_r;
    logic signed [15:0] row_buf_r [ROW_W];

    logic               in_ready_r;
    logic               out_start_r;
    logic               out_enable_r;
    logic signed [15:0] out_data_r;
    logic               frame_done_r;

    logic               accept_s;
    logic               frame_done_s;
    logic signed [15:0] out_data_s;

    // in_ready_r always mirrors the state, so it doubles as the internal accept gate.
    assign accept_s = in_valid && in_ready_r;

    // Next-state and beat sequencing.
    always_comb begin
        next_state_s = state_r;
        next_beat_s  = beat_r;
        if (!run) begin
            next_state_s = IDLE;
            next_beat_s  = 3'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    next_state_s = FILL;
                    next_beat_s  = 3'd0;
                end
                FILL: begin
                    if (accept_s && (col_r == COL_LAST)) begin
                        next_state_s = LOAD_A;
                    end else begin
                        next_state_s = FILL;
                    end
                end
                LOAD_A: begin
                    if (accept_s) begin
                        next_state_s = LOAD_B;
                    end else begin
                        next_state_s = LOAD_A;
                    end
                end
                LOAD_B: begin
                    if (accept_s) begin
                        next_state_s = EMIT;
                        next_beat_s  = 3'd0;
                    end else begin
                        next_state_s = LOAD_B;
                    end
                end
                EMIT: begin
                    if (beat_r == BEAT_GAP) begin
                        next_beat_s = 3'd0;
                        if (col_r == '0) begin
                            next_state_s = FILL;
                        end else begin
                            next_state_s = LOAD_A;
                        end
                    end else begin
                        next_state_s = EMIT;
                        next_beat_s  = beat_r + 3'd1;
                    end
                end
                default: begin
                    next_state_s = IDLE;
                    next_beat_s  = 3'd0;
                end
            endcase
        end
    end

    // Counters only move on accepted pixels, so the wrapped values mark the last window of the frame.
    assign frame_done_s = (next_state_s == EMIT) && (next_beat_s == BEAT_GAP) &&
                          (col_r == '0) && (row_r == '0);

    // Window element selected for the upcoming cycle.
    always_comb begin
        out_data_s = 16'sd0;
        if (next_state_s == EMIT) begin
            case (next_beat_s)
                3'd0:    out_data_s = row_buf_r[base_r];
                3'd1:    out_data_s = row_buf_r[base_r + CW'(1)];
                3'd2:    out_data_s = hold_a_r;
                3'd3:    out_data_s = hold_b_r;
                default: out_data_s = 16'sd0;
            endcase
        end else begin
            out_data_s = 16'sd0;
        end
    end

    // State, position counters and odd-row holding registers.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_r  <= IDLE;
            beat_r   <= 3'd0;
            col_r    <= '0;
            row_r    <= '0;
            base_r   <= '0;
            hold_a_r <= 16'sd0;
            hold_b_r <= 16'sd0;
        end else begin
            state_r <= next_state_s;
            beat_r  <= next_beat_s;
            if (!run) begin
                col_r <= '0;
                row_r <= '0;
            end else if (accept_s) begin
                if (col_r == COL_LAST) begin
                    col_r <= '0;
                    row_r <= (row_r == ROW_LAST) ? '0 : row_r + RW'(1);
                end else begin
                    col_r <= col_r + CW'(1);
                end
                if (state_r == LOAD_A) begin
                    hold_a_r <= in_data;
                    base_r   <= col_r;
                end else if (state_r == LOAD_B) begin
                    hold_b_r <= in_data;
                end
            end
        end
    end

    // Even-row line buffer; deliberately not reset.
    always_ff @(posedge clk) begin
        if (run && accept_s && (state_r == FILL)) begin
            row_buf_r[col_r] <= in_data;
        end
    end

    // Outputs registered from the next state so they line up with the state they describe.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            in_ready_r   <= 1'b0;
            out_start_r  <= 1'b0;
            out_enable_r <= 1'b0;
            out_data_r   <= 16'sd0;
            frame_done_r <= 1'b0;
        end else begin
            in_ready_r   <= (next_state_s == FILL) || (next_state_s == LOAD_A) ||
                            (next_state_s == LOAD_B);
            out_start_r  <= (next_state_s != IDLE);
            out_enable_r <= (next_state_s == EMIT) && (next_beat_s != BEAT_GAP);
            out_data_r   <= out_data_s;
            frame_done_r <= frame_done_s;
        end
    end

    assign in_ready   = in_ready_r;
    assign out_start  = out_start_r;
    assign out_enable = out_enable_r;
    assign out_data   = out_data_r;
    assign frame_done = frame_done_r;

endmodule

// File: tb/tb_pool_window_feeder.sv
// Directed bench: a 4x2 instance for the small window and latency cases, an 8x8 instance
// for full-frame, stall, abort and async-reset cases; both share one input stream.
module tb_pool_window_feeder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               n_reset;
    logic               run;
    logic               in_valid;
    logic signed [15:0] in_data;
    logic               ir4, os4, oe4, fd4;
    logic signed [15:0] od4;
    logic               ir8, os8, oe8, fd8;
    logic signed [15:0] od8;

    pool_window_feeder #(.ROW_W(4), .IMG_H(2)) u_dut4 (
        .clk(clk), .n_reset(n_reset), .run(run), .in_valid(in_valid), .in_data(in_data),
        .in_ready(ir4), .out_start(os4), .out_enable(oe4), .out_data(od4), .frame_done(fd4)
    );

    pool_window_feeder #(.ROW_W(8), .IMG_H(8)) u_dut8 (
        .clk(clk), .n_reset(n_reset), .run(run), .in_valid(in_valid), .in_data(in_data),
        .in_ready(ir8), .out_start(os8), .out_enable(oe8), .out_data(od8), .frame_done(fd8)
    );

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    bit sel;

    logic signed [15:0] q4 [$];
    logic signed [15:0] q8 [$];
    int t4 [$];
    int t8 [$];
    int fd4_n, fd8_n, fd4_t, fd8_t;
    int bad4 = 0;
    int bad8 = 0;
    logic signed [15:0] pix [64];
    int tacc [64];
    int v2 [8] = '{-3, -1, -32768, 5, -7, 32767, 100, -2};
    int e2 [8] = '{-3, -1, -7, 32767, -32768, 5, 100, -2};
    int e1 [8] = '{1, 2, 5, 6, 3, 4, 7, 8};

    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (oe4) begin
            q4.push_back(od4);
            t4.push_back(cyc);
        end else if (od4 !== 16'sd0) begin
            bad4++;
        end
        if (fd4) begin
            fd4_n++;
            fd4_t = cyc;
        end
        if (oe8) begin
            q8.push_back(od8);
            t8.push_back(cyc);
        end else if (od8 !== 16'sd0) begin
            bad8++;
        end
        if (fd8) begin
            fd8_n++;
            fd8_t = cyc;
        end
    end

    task automatic check(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic clear_mon();
        q4.delete();
        q8.delete();
        t4.delete();
        t8.delete();
        fd4_n = 0;
        fd8_n = 0;
        fd4_t = -1;
        fd8_t = -1;
    endtask

    // Offer one pixel to the selected instance; called away from the rising edge.
    task automatic push(input logic signed [15:0] v, input bit gappy, output int t_acc);
        int guard;
        guard = 0;
        while (!(sel ? ir8 : ir4) && guard < 100) begin
            in_valid = 1'b0;
            @(negedge clk);
            guard++;
        end
        t_acc = cyc;
        if (guard >= 100) begin
            check("push_timeout", 0, 1);
        end else begin
            in_valid = 1'b1;
            in_data  = v;
            @(negedge clk);
            in_valid = 1'b0;
            in_data  = 16'sh7E7E;
            if (gappy) @(negedge clk);
        end
    endtask

    task automatic wait_beats(input int n);
        int guard;
        guard = 0;
        #1;
        while (((sel ? q8.size() : q4.size()) < n) && guard < 400) begin
            @(negedge clk);
            #1;
            guard++;
        end
        if (guard >= 400) check("beat_timeout", sel ? q8.size() : q4.size(), n);
    endtask

    task automatic restart();
        @(negedge clk);
        run      = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        clear_mon();
        @(negedge clk);
        run = 1'b1;
    endtask

    // Expected beat k of the 8-wide instance given pixels in pix[].
    function automatic int exp8(input int k);
        int w, b, r, c;
        w = k / 4;
        b = k % 4;
        r = 2 * (w / 4) + (b / 2);
        c = 2 * (w % 4) + (b % 2);
        return pix[8 * r + c];
    endfunction

    initial begin
        n_reset  = 1'b0;
        run      = 1'b1;
        in_valid = 1'b0;
        in_data  = 16'sd0;
        sel      = 1'b1;
        clear_mon();

        #12;
        check("rst_ir4", ir4, 0);
        check("rst_os4", os4, 0);
        check("rst_oe4", oe4, 0);
        check("rst_od4", od4, 0);
        check("rst_fd4", fd4, 0);
        check("rst_ir8", ir8, 0);
        check("rst_os8", os8, 0);
        check("rst_oe8", oe8, 0);
        check("rst_od8", od8, 0);
        check("rst_fd8", fd8, 0);
        @(negedge clk);
        n_reset = 1'b1;
        @(negedge clk);
        check("rel_ir8", ir8, 1);
        check("rel_os8", os8, 1);
        check("rel_ir4", ir4, 1);
        clear_mon();

        // Small 4x2 frame: window order, latency and frame_done.
        sel = 1'b0;
        for (int i = 0; i < 8; i++) push(16'(i + 1), 1'b0, tacc[i]);
        wait_beats(8);
        @(negedge clk);
        #1;
        check("t1_gap_fd", fd4, 1);
        check("t1_gap_oe", oe4, 0);
        check("t1_gap_ir", ir4, 0);
        @(negedge clk);
        #1;
        check("t1_refill_ir", ir4, 1);
        check("t1_refill_os", os4, 1);
        for (int i = 0; i < 8; i++) check($sformatf("t1_beat%0d", i), q4[i], e1[i]);
        check("t1_lat_first", t4[0], tacc[5] + 1);
        check("t1_lat_last", t4[3], tacc[5] + 4);
        check("t1_ready_again", tacc[6], tacc[5] + 6);
        check("t1_win2_start", t4[4], tacc[7] + 1);
        check("t1_fd_count", fd4_n, 1);
        check("t1_fd_time", fd4_t, t4[7] + 1);

        // Signed extremes pass through unchanged.
        restart();
        sel = 1'b0;
        for (int i = 0; i < 8; i++) push(16'(v2[i]), 1'b0, tacc[i]);
        wait_beats(8);
        for (int i = 0; i < 8; i++) check($sformatf("t2_beat%0d", i), q4[i], e2[i]);

        // Full 8x8 frame, then back-to-back into the next frame.
        restart();
        sel = 1'b1;
        for (int i = 0; i < 64; i++) pix[i] = 16'(i);
        for (int i = 0; i < 64; i++) push(pix[i], 1'b0, tacc[i]);
        wait_beats(64);
        @(negedge clk);
        #1;
        check("t3_gap_fd", fd8, 1);
        check("t3_gap_oe", oe8, 0);
        @(negedge clk);
        #1;
        check("t3_next_os", os8, 1);
        check("t3_next_ir", ir8, 1);
        for (int k = 0; k < 64; k++) check($sformatf("t3_beat%0d", k), q8[k], exp8(k));
        check("t3_fd_count", fd8_n, 1);
        check("t3_fd_time", fd8_t, t8[63] + 1);

        // Stalled input with junk data between valid pixels.
        restart();
        sel = 1'b1;
        for (int i = 0; i < 16; i++) pix[i] = 16'(1000 - 37 * i);
        for (int i = 0; i < 16; i++) push(pix[i], 1'b1, tacc[i]);
        wait_beats(16);
        check("t4_count", q8.size(), 16);
        for (int k = 0; k < 16; k++) check($sformatf("t4_beat%0d", k), q8[k], exp8(k));

        // Abort during beat 1, then a fresh frame.
        restart();
        sel = 1'b1;
        for (int i = 0; i < 10; i++) pix[i] = 16'(300 + i);
        for (int i = 0; i < 10; i++) push(pix[i], 1'b0, tacc[i]);
        @(negedge clk);
        check("t5_beat1_oe", oe8, 1);
        check("t5_beat1_od", od8, pix[1]);
        run = 1'b0;
        @(negedge clk);
        #1;
        check("t5_abort_oe", oe8, 0);
        check("t5_abort_od", od8, 0);
        check("t5_abort_os", os8, 0);
        check("t5_abort_ir", ir8, 0);
        check("t5_abort_fd", fd8, 0);
        check("t5_abort_beats", q8.size(), 2);
        clear_mon();
        run = 1'b1;
        for (int i = 0; i < 16; i++) pix[i] = 16'(400 + i);
        for (int i = 0; i < 16; i++) push(pix[i], 1'b0, tacc[i]);
        wait_beats(16);
        for (int k = 0; k < 16; k++) check($sformatf("t5_fresh%0d", k), q8[k], exp8(k));

        // Asynchronous reset while a window is being emitted.
        restart();
        sel = 1'b1;
        for (int i = 0; i < 10; i++) pix[i] = 16'(500 + i);
        for (int i = 0; i < 10; i++) push(pix[i], 1'b0, tacc[i]);
        @(posedge clk);
        #2;
        check("t6_pre_oe", oe8, 1);
        n_reset = 1'b0;
        #1;
        check("t6_async_oe", oe8, 0);
        check("t6_async_od", od8, 0);
        check("t6_async_os", os8, 0);
        check("t6_async_ir", ir8, 0);
        check("t6_async_fd", fd8, 0);
        @(negedge clk);
        n_reset = 1'b1;
        @(negedge clk);
        check("t6_rel_ir", ir8, 1);
        check("t6_rel_os", os8, 1);

        check("idle_data4", bad4, 0);
        check("idle_data8", bad8, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
